// File: rtl/sad_array_accum.sv
// Per-candidate SAD accumulator for motion estimation: one current pixel plus
// N_CAND reference pixels per beat, with saturating sums published at block end.
module sad_array_accum #(
  parameter int N_CAND  = 16,
  parameter int PIX_W   = 8,
  parameter int SAD_W   = 16,
  parameter int BLK_PIX = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [PIX_W-1:0]          cur_pix,
  input  logic [N_CAND*PIX_W-1:0]   ref_pix,
  output logic [N_CAND*SAD_W-1:0]   sad_results,
  output logic                      block_done,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int CNT_W = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
  localparam int SUM_W = ((SAD_W > PIX_W) ? SAD_W : PIX_W) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX   = {{(SUM_W-SAD_W){1'b0}}, {SAD_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SAD_W-1:0]          acc_q [N_CAND];
  logic [SAD_W-1:0]          acc_d [N_CAND];
  logic [N_CAND*SAD_W-1:0]   sad_q, sad_d;

  logic [PIX_W:0]            diff_w  [N_CAND];
  logic [PIX_W:0]            neg_w   [N_CAND];
  logic [PIX_W-1:0]          abs_w   [N_CAND];
  logic [SUM_W-1:0]          raw_sum [N_CAND];
  logic [SAD_W-1:0]          sat_sum [N_CAND];

  // Widened difference keeps the borrow so |a-b| is exact for unsigned pixels.
  always_comb begin
    for (int i = 0; i < N_CAND; i++) begin
      diff_w[i]  = {1'b0, cur_pix} - {1'b0, ref_pix[PIX_W*i +: PIX_W]};
      neg_w[i]   = -diff_w[i];
      abs_w[i]   = diff_w[i][PIX_W] ? neg_w[i][PIX_W-1:0] : diff_w[i][PIX_W-1:0];
      raw_sum[i] = SUM_W'(acc_q[i]) + SUM_W'(abs_w[i]);
      sat_sum[i] = (raw_sum[i] > SAT_MAX) ? {SAD_W{1'b1}} : raw_sum[i][SAD_W-1:0];
    end
  end

  // Valid/ready: a beat is consumed on an edge where pix_valid && pix_ready;
  // pix_ready depends only on state, so the producer may hold pix_valid freely.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sad_d     = sad_q;
    pix_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          for (int i = 0; i < N_CAND; i++) acc_d[i] = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (cnt_q == LAST_BEAT) begin
            for (int i = 0; i < N_CAND; i++) begin
              sad_d[SAD_W*i +: SAD_W] = sat_sum[i];
              acc_d[i]                = '0;
            end
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d = sat_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sad_q   <= '0;
      for (int i = 0; i < N_CAND; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sad_q   <= sad_d;
      for (int i = 0; i < N_CAND; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign sad_results = sad_q;
  assign block_done  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sad_array_accum.sv
// Bench for sad_array_accum: default instance plus a SAD_W=12 instance sharing
// one stimulus stream, checked against a per-block arithmetic model.
module tb_sad_array_accum;

  localparam int N   = 16;
  localparam int PW  = 8;
  localparam int BLK = 64;
  localparam int W16 = 16;
  localparam int W12 = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              pix_valid = 1'b0;
  logic [PW-1:0]     cur_pix = '0;
  logic [N*PW-1:0]   ref_pix = '0;

  logic              pix_ready, block_done, busy;
  logic [N*W16-1:0]  sad16;
  logic [1:0]        dbg16;
  logic              pix_ready12, block_done12, busy12;
  logic [N*W12-1:0]  sad12;
  logic [1:0]        dbg12;

  sad_array_accum u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .cur_pix(cur_pix), .ref_pix(ref_pix),
    .sad_results(sad16), .block_done(block_done), .busy(busy), .dbg_state(dbg16)
  );

  sad_array_accum #(.SAD_W(W12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_ready(pix_ready12), .cur_pix(cur_pix), .ref_pix(ref_pix),
    .sad_results(sad12), .block_done(block_done12), .busy(busy12), .dbg_state(dbg12)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard
  logic [N*W16-1:0] exp_q[$];
  logic [N*W12-1:0] exp12_q[$];
  logic [N*W16-1:0] hold16 = '0;
  logic [N*W12-1:0] hold12 = '0;
  int cur_a [BLK];
  int ref_a [BLK][N];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    cur_pix = PW'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) ref_pix[PW*i +: PW] = PW'($urandom_range(0, 255));
  endtask

  task automatic drive_beat(input int k);
    cur_pix = PW'(cur_a[k]);
    for (int i = 0; i < N; i++) ref_pix[PW*i +: PW] = PW'(ref_a[k][i]);
  endtask

  // mode 0 uniform (ref=cur+i), 1 max diff, 2 constant |diff|=d, 3 random
  task automatic gen_block(input int mode, input int d);
    for (int k = 0; k < BLK; k++) begin
      case (mode)
        0: cur_a[k] = 100;
        1: cur_a[k] = 0;
        2: cur_a[k] = $urandom_range(d, 255 - d);
        default: cur_a[k] = $urandom_range(0, 255);
      endcase
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: ref_a[k][i] = 100 + i;
          1: ref_a[k][i] = 255;
          2: ref_a[k][i] = ($urandom_range(0, 1) == 1) ? cur_a[k] + d : cur_a[k] - d;
          default: ref_a[k][i] = $urandom_range(0, 255);
        endcase
      end
    end
  endtask

  // Reference: plain sum of absolute differences, clamped to the SAD range.
  task automatic predict();
    logic [N*W16-1:0] e16;
    logic [N*W12-1:0] e12;
    for (int i = 0; i < N; i++) begin
      int s = 0;
      for (int k = 0; k < BLK; k++)
        s += (cur_a[k] > ref_a[k][i]) ? cur_a[k] - ref_a[k][i] : ref_a[k][i] - cur_a[k];
      e16[W16*i +: W16] = W16'((s > 65535) ? 65535 : s);
      e12[W12*i +: W12] = W12'((s > 4095) ? 4095 : s);
    end
    exp_q.push_back(e16);
    exp12_q.push_back(e12);
  endtask

  // gap_mode: 0 none, 1 every 3rd cycle stalled, 2 random stalls.
  // abort_at >= 0 pulls reset after that many accepted beats.
  task automatic run_block(input int gap_mode, input int abort_at);
    int k = 0;
    int cyc = 0;
    bit stall;
    logic [N*W16-1:0] e16;
    logic [N*W12-1:0] e12;
    predict();
    chk("idle_busy_ready", {busy, busy12, pix_ready, pix_ready12}, 4'h0);
    start = 1'b1; pix_valid = 1'b1; junk();   // beat offered with start must be ignored
    tick();
    start = 1'b0;
    chk("accum_entry", {busy, busy12, pix_ready, pix_ready12}, 4'hf);
    while (k < BLK && cyc < 4 * BLK) begin
      if (abort_at >= 0 && k == abort_at) break;
      stall = (gap_mode == 1 && (cyc % 3) == 2) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
      start = $urandom_range(0, 1);
      if (stall) begin
        pix_valid = 1'b0; junk();
      end else begin
        pix_valid = 1'b1; drive_beat(k);
      end
      chk("accum_ready_busy", {busy, busy12, pix_ready, pix_ready12}, 4'hf);
      chk("early_done", {block_done, block_done12}, 2'b00);
      chk("sad_hold16", sad16, hold16);
      chk("sad_hold12", sad12, hold12);
      tick();
      if (!stall) k++;
      cyc++;
    end
    if (abort_at >= 0 && k == abort_at) begin
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {block_done, busy, pix_ready, block_done12, busy12, pix_ready12}, 6'h0);
      chk("abort_sad16", sad16, '0);
      chk("abort_sad12", sad12, '0);
      void'(exp_q.pop_front());
      void'(exp12_q.pop_front());
      hold16 = '0; hold12 = '0;
      start = 1'b0; pix_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      return;
    end
    if (k < BLK) begin
      chk("beat_timeout", 256'(k), 256'(BLK));
      start = 1'b0; pix_valid = 1'b0;
      return;
    end
    e16 = exp_q.pop_front();
    e12 = exp12_q.pop_front();
    chk("done_pulse", {block_done, block_done12}, 2'b11);
    chk("done_ready_busy", {pix_ready, pix_ready12, busy, busy12}, 4'b0011);
    chk("sad16", sad16, e16);
    chk("sad12", sad12, e12);
    hold16 = e16; hold12 = e12;
    start = 1'b1; pix_valid = 1'b1; junk();   // ignored in DONE
    tick();
    chk("after_done", {block_done, block_done12, busy, busy12}, 4'h0);
    chk("after_done_sad16", sad16, hold16);
    chk("after_done_sad12", sad12, hold12);
    start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic idle_hold(input int n);
    for (int c = 0; c < n; c++) begin
      pix_valid = 1'b1; junk();
      tick();
      chk("idle_ready", {pix_ready, pix_ready12, busy, busy12, block_done}, 5'h0);
      chk("idle_sad16", sad16, hold16);
      chk("idle_sad12", sad12, hold12);
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_outputs", {block_done, busy, pix_ready, block_done12, busy12, pix_ready12}, 6'h0);
    chk("reset_sad16", sad16, '0);
    chk("reset_sad12", sad12, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    gen_block(0, 0);  run_block(0, -1);
    chk("uniform_cand15", 256'(sad16[W16*15 +: W16]), 256'(960));
    idle_hold(3);
    gen_block(1, 0);  run_block(0, -1);
    chk("maxdiff_cand0_16", 256'(sad16[W16*0 +: W16]), 256'(16320));
    chk("maxdiff_cand0_12", 256'(sad12[W12*0 +: W12]), 256'(4095));
    gen_block(0, 0);  run_block(1, -1);
    gen_block(2, 1);  run_block(2, -1);
    idle_hold(2);
    gen_block(2, 2);  run_block(1, -1);   // back-to-back: starts in first IDLE cycle
    chk("diff2_cand7", 256'(sad16[W16*7 +: W16]), 256'(128));
    gen_block(2, 3);  run_block(0, 30);
    gen_block(2, 3);  run_block(2, -1);
    chk("diff3_cand3", 256'(sad16[W16*3 +: W16]), 256'(192));
    for (int b = 0; b < 3; b++) begin
      gen_block(3, 0);
      run_block(b % 3, -1);
    end
    idle_hold(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
